// File: rtl/and2_bist_checker_if.sv
// Bundle of the BIST engine's run handshake, gate drive/return and result signals.
// The master side requests runs and returns the gate output; the slave side is the engine.
interface and2_bist_checker_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             dut_a;
    logic             dut_b;
    logic             dut_c;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic             first_fail_valid;
    logic [1:0]       first_fail_vec;

    modport master (
        output start,
        output dut_c,
        input  dut_a,
        input  dut_b,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_fail_valid,
        input  first_fail_vec
    );

    modport slave (
        input  start,
        input  dut_c,
        output dut_a,
        output dut_b,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_fail_valid,
        output first_fail_vec
    );
endinterface

// File: rtl/and2_bist_checker.sv
// Built-in self-test engine for a two-input AND gate: walks all four input vectors,
// samples the gate output after a settle interval and accumulates mismatches.
module and2_bist_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    and2_bist_checker_if.slave   io_bist
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [7:0]       SETTLE_LOAD = 8'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
    localparam logic [7:0]       LOOP_LAST   = 8'(LOOPS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    state_t           r_state;
    logic [1:0]       r_vec;
    logic [7:0]       r_loop;
    logic [7:0]       r_settle_cnt;
    logic             r_dut_a;
    logic             r_dut_b;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err_count;
    logic             r_ff_valid;
    logic [1:0]       r_ff_vec;
    logic             r_mismatch_seen;

    logic             w_mismatch;
    logic             w_last;
    logic [1:0]       w_vec_next;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt);
        return (cnt == ERR_MAX) ? cnt : cnt + {{(ERR_W-1){1'b0}}, 1'b1};
    endfunction

    assign w_mismatch = io_bist.dut_c != (r_dut_a & r_dut_b);
    assign w_last     = (r_vec == 2'd3) && (r_loop == LOOP_LAST);
    assign w_vec_next = r_vec + 2'd1;

    // Sequencer: one state per phase of a vector; every output is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_vec           <= 2'd0;
            r_loop          <= 8'd0;
            r_settle_cnt    <= 8'd0;
            r_dut_a         <= 1'b0;
            r_dut_b         <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_err_count     <= {ERR_W{1'b0}};
            r_ff_valid      <= 1'b0;
            r_ff_vec        <= 2'd0;
            r_mismatch_seen <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (io_bist.start) begin
                        r_vec           <= 2'd0;
                        r_loop          <= 8'd0;
                        r_err_count     <= {ERR_W{1'b0}};
                        r_ff_valid      <= 1'b0;
                        r_ff_vec        <= 2'd0;
                        r_pass          <= 1'b0;
                        r_mismatch_seen <= 1'b0;
                        r_dut_a         <= 1'b0;
                        r_dut_b         <= 1'b0;
                        r_busy          <= 1'b1;
                        r_state         <= ST_APPLY;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_APPLY: begin
                    if (SETTLE_CYCLES > 0) begin
                        r_settle_cnt <= SETTLE_LOAD;
                        r_state      <= ST_SETTLE;
                    end else begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == 8'd0) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 8'd1;
                    end
                end
                ST_CHECK: begin
                    if (w_mismatch) begin
                        r_err_count     <= sat_inc(r_err_count);
                        r_mismatch_seen <= 1'b1;
                        if (!r_ff_valid) begin
                            r_ff_valid <= 1'b1;
                            r_ff_vec   <= {r_dut_a, r_dut_b};
                        end
                    end
                    if (w_last) begin
                        // Pass uses the sticky flag so a saturated counter cannot hide failures.
                        r_pass  <= !(r_mismatch_seen || w_mismatch);
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_vec   <= w_vec_next;
                        r_dut_a <= w_vec_next[1];
                        r_dut_b <= w_vec_next[0];
                        if (r_vec == 2'd3) begin
                            r_loop <= r_loop + 8'd1;
                        end
                        r_state <= ST_APPLY;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bist.dut_a            = r_dut_a;
    assign io_bist.dut_b            = r_dut_b;
    assign io_bist.busy             = r_busy;
    assign io_bist.done             = r_done;
    assign io_bist.pass             = r_pass;
    assign io_bist.err_count        = r_err_count;
    assign io_bist.first_fail_valid = r_ff_valid;
    assign io_bist.first_fail_vec   = r_ff_vec;

endmodule
